jtcps1_starfield_n: RTL and testbench

// - Multi-layer star field generator for the CPS1 video pipeline.
// - Sits beside the scroll layers; its per-layer 9-bit pixel codes feed the colour mixer.
// - Each layer has a scrollable LFSR sequence, a double-buffered scroll latch, an enable
//   and a frame-driven colour cycle.
// - Generalises the two-layer star unit to LAYERS layers, parametric LFSR width/taps and density.

---
 rtl/jtcps1_starfield_n_pkg.sv | 19 +
 rtl/jtcps1_starfield_n_lfsr.sv | 58 +++++
 rtl/jtcps1_starfield_n.sv | 110 +++++++++++
 tb/tb_jtcps1_starfield_n.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_starfield_n_pkg.sv
// Shared constants and helpers for the CPS1 star field generator.
//   SEED_LO   : low 10 bits of every reseed value (inverted on odd layers)
//   SEED_XOR  : pattern XORed into the top nibble of the seed (inverted on odd layers)
//   STAR_CLR  : pixel code meaning "no star here"
//   star_seed : builds the 23-bit reseed word from the layer parity and the scrolled line
package jtcps1_starfield_n_pkg;

   localparam logic [9:0] SEED_LO  = 10'h55;
   localparam logic [3:0] SEED_XOR = 4'b0110;
   localparam logic [3:0] STAR_CLR = 4'hf;

   typedef logic [8:0] pix9_t;

   // b selects the odd/even flavour so adjacent layers never share a sequence.
   function automatic logic [22:0] star_seed(input logic b, input pix9_t v);
      return {SEED_XOR ^ {4{b}} ^ {v[3:2], v[7:6]}, v[3:0], v[8:4], SEED_LO ^ {10{b}}};
   endfunction

endpackage

// File: rtl/jtcps1_starfield_n_lfsr.sv
// One star layer: LFSR, horizontal pre-roll counter and reseed logic.
// Ports:
//   clk, rst   : video clock, synchronous active-high reset
//   pxl_cen    : pixel clock enable, steps the LFSR outside of blanking
//   load       : HB|VB, blanking window
//   load_rise  : first cycle of blanking, reseeds the layer
//   vpos       : latched vertical scroll for this layer
//   vdump      : current line
//   hpos       : latched horizontal scroll, number of pre-roll steps
//   low        : poly[DENS+6:0], everything the output stage needs
module jtcps1_starfield_n_lfsr
   import jtcps1_starfield_n_pkg::*;
#(
   parameter int   PW   = 23,
   parameter int   TAPA = 21,
   parameter int   TAPB = 17,
   parameter int   DENS = 9,
   parameter logic B    = 1'b0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            pxl_cen,
   input  logic            load,
   input  logic            load_rise,
   input  logic [8:0]      vpos,
   input  logic [8:0]      vdump,
   input  logic [8:0]      hpos,
   output logic [DENS+6:0] low
);

   logic [PW-1:0] poly;
   logic [8:0]    cnt;
   pix9_t         v;
   logic          step;

   assign v = vpos + vdump;

   // During blanking the sequence pre-rolls at clk rate until the scroll
   // count is used up; outside blanking it follows the pixel enable.
   // An unfinished pre-roll simply keeps counting down at pixel rate.
   assign step = load ? (cnt != 9'd0) : pxl_cen;

   always_ff @(posedge clk) begin
      if (rst) begin
         poly <= '0;
         cnt  <= '0;
      end else if (load_rise) begin
         poly <= PW'(star_seed(B, v));
         cnt  <= hpos;
      end else if (step) begin
         poly <= {poly[PW-2:0], ~(poly[TAPA] ^ poly[TAPB])};
         if (cnt != 9'd0) cnt <= cnt - 9'd1;
      end
   end

   assign low = poly[DENS+6:0];

endmodule

// File: rtl/jtcps1_starfield_n.sv
// Multi-layer star field generator for the CPS1 video pipeline.
// Each layer owns an LFSR that is reseeded at the start of every blanking
// window and pre-rolled by its horizontal scroll. Scroll values and the colour
// cycle enables are latched once per frame on the rising edge of VB.
// Ports:
//   clk, rst   : video clock, synchronous active-high reset
//   pxl_cen    : pixel clock enable
//   HB, VB     : horizontal / vertical blank
//   vdump      : current line
//   hpos, vpos : per-layer scroll, layer k in bits [9k+8:9k]
//   layer_en   : per-layer visibility enable
//   cyc_en     : per-layer colour cycling enable
//   star       : per-layer 9-bit pixel code {2'd0, col[2:0], pix[3:0]}, pix 4'hf = transparent
module jtcps1_starfield_n
   import jtcps1_starfield_n_pkg::*;
#(
   parameter int LAYERS = 2,
   parameter int PW     = 23,
   parameter int TAPA   = 21,
   parameter int TAPB   = 17,
   parameter int DENS   = 9,
   parameter int CYC_SH = 3
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                pxl_cen,
   input  logic                HB,
   input  logic                VB,
   input  logic [8:0]          vdump,
   input  logic [9*LAYERS-1:0] hpos,
   input  logic [9*LAYERS-1:0] vpos,
   input  logic [LAYERS-1:0]   layer_en,
   input  logic [LAYERS-1:0]   cyc_en,
   output logic [9*LAYERS-1:0] star
);

   logic                last_vb;
   logic                last_load;
   logic                load;
   logic                load_rise;
   logic                vb_rise;
   logic [9*LAYERS-1:0] hpos_sh;
   logic [9*LAYERS-1:0] vpos_sh;
   logic [LAYERS-1:0]   cyc_sh;
   logic [CYC_SH+2:0]   fcnt;

   assign load      = HB | VB;
   assign load_rise = load & ~last_load;
   assign vb_rise   = VB & ~last_vb;

   // Scroll writes from the CPU land whenever they like; the shadow copies
   // keep a frame internally consistent.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_vb   <= 1'b0;
         last_load <= 1'b0;
         hpos_sh   <= '0;
         vpos_sh   <= '0;
         cyc_sh    <= '0;
         fcnt      <= '0;
      end else begin
         last_vb   <= VB;
         last_load <= load;
         if (vb_rise) begin
            hpos_sh <= hpos;
            vpos_sh <= vpos;
            cyc_sh  <= cyc_en;
            fcnt    <= fcnt + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < LAYERS; k++) begin : g_layer
      logic [DENS+6:0] low;
      logic [2:0]      col;
      logic            lit;
      logic [8:0]      star_q;

      jtcps1_starfield_n_lfsr #(
         .PW   (PW),
         .TAPA (TAPA),
         .TAPB (TAPB),
         .DENS (DENS),
         .B    (1'(k % 2))
      ) u_lfsr (
         .clk       (clk),
         .rst       (rst),
         .pxl_cen   (pxl_cen),
         .load      (load),
         .load_rise (load_rise),
         .vpos      (vpos_sh[9*k +: 9]),
         .vdump     (vdump),
         .hpos      (hpos_sh[9*k +: 9]),
         .low       (low)
      );

      // Colour cycle: the top three frame counter bits rotate the palette.
      assign col = low[6:4] + (cyc_sh[k] ? fcnt[CYC_SH+2:CYC_SH] : 3'd0);
      // Disabled layers keep stepping so re-enabling stays aligned.
      assign lit = layer_en[k] & (&low[DENS+6:7]) & ~load;

      always_ff @(posedge clk) begin
         if (rst) star_q <= {5'd0, STAR_CLR};
         else     star_q <= {2'd0, col, lit ? low[3:0] : STAR_CLR};
      end

      assign star[9*k +: 9] = star_q;
   end

endmodule

// File: tb/tb_jtcps1_starfield_n.sv
module tb_jtcps1_starfield_n;

   localparam int LAYERS = 2;
   localparam int DENS   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                pxl_cen;
   logic                HB;
   logic                VB;
   logic [8:0]          vdump;
   logic [9*LAYERS-1:0] hpos;
   logic [9*LAYERS-1:0] vpos;
   logic [LAYERS-1:0]   layer_en;
   logic [LAYERS-1:0]   cyc_en;
   logic [9*LAYERS-1:0] star;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jtcps1_starfield_n #(
      .LAYERS (LAYERS),
      .PW     (23),
      .TAPA   (21),
      .TAPB   (17),
      .DENS   (DENS),
      .CYC_SH (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (pxl_cen),
      .HB       (HB),
      .VB       (VB),
      .vdump    (vdump),
      .hpos     (hpos),
      .vpos     (vpos),
      .layer_en (layer_en),
      .cyc_en   (cyc_en),
      .star     (star)
   );

   // ---------------- reference model ----------------
   logic [22:0] m_poly [LAYERS];
   int          m_cnt  [LAYERS];
   int          m_hsh  [LAYERS];
   int          m_vsh  [LAYERS];
   bit          m_cyc  [LAYERS];
   logic [8:0]  m_star [LAYERS];
   int          m_fcnt;
   bit          m_ll;
   bit          m_lv;

   function automatic logic [22:0] seed_of(input int b, input int v);
      int top, r;
      top = (b ? 9 : 6) ^ ((((v >> 2) & 3) << 2) | ((v >> 6) & 3));
      r = (top << 19) | ((v & 15) << 15) | (((v >> 4) & 31) << 10) | (b ? 'h3aa : 'h55);
      return r[22:0];
   endfunction

   function automatic logic [22:0] lfsr_next(input logic [22:0] p);
      int x, fb;
      x  = int'(p);
      fb = (((x >> 21) ^ (x >> 17)) & 1) ^ 1;
      x  = ((x << 1) | fb) & 'h7fffff;
      return x[22:0];
   endfunction

   task automatic model_step();
      bit load, lr, vr;
      load = HB | VB;
      lr   = load && !m_ll;
      vr   = VB && !m_lv;
      if (rst) begin
         for (int k = 0; k < LAYERS; k++) begin
            m_poly[k] = '0; m_cnt[k] = 0; m_hsh[k] = 0; m_vsh[k] = 0;
            m_cyc[k] = 0; m_star[k] = 9'h00f;
         end
         m_fcnt = 0; m_ll = 0; m_lv = 0;
         return;
      end
      for (int k = 0; k < LAYERS; k++) begin
         int x, c, mask;
         bit vis;
         x    = int'(m_poly[k]);
         mask = (1 << DENS) - 1;
         c    = ((x >> 4) + (m_cyc[k] ? ((m_fcnt >> 3) & 7) : 0)) & 7;
         vis  = layer_en[k] && (((x >> 7) & mask) == mask) && !load;
         m_star[k] = 9'((c << 4) | (vis ? (x & 15) : 15));
         if (lr) begin
            m_poly[k] = seed_of(k & 1, (m_vsh[k] + int'(vdump)) & 511);
            m_cnt[k]  = m_hsh[k];
         end else if ((!load && pxl_cen) || (load && m_cnt[k] != 0)) begin
            m_poly[k] = lfsr_next(m_poly[k]);
            if (m_cnt[k] > 0) m_cnt[k]--;
         end
      end
      if (vr) begin
         for (int k = 0; k < LAYERS; k++) begin
            m_hsh[k] = int'(hpos[9*k +: 9]);
            m_vsh[k] = int'(vpos[9*k +: 9]);
            m_cyc[k] = cyc_en[k];
         end
         m_fcnt = (m_fcnt + 1) & 63;
      end
      m_ll = load;
      m_lv = VB;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < LAYERS; k++) begin
         total++;
         if (star[9*k +: 9] !== m_star[k]) begin
            bad++;
            $display("FAIL star%0d at %0t: got %h want %h", k, $time, star[9*k +: 9], m_star[k]);
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic run_line(input int act, input int hbl, input bit rnd_writes);
      HB = 1'b0;
      for (int i = 0; i < act; i++) begin
         pxl_cen = ($urandom_range(0, 3) != 0);
         if (rnd_writes && i == act / 2) begin
            hpos   = {9'($urandom_range(0, 20)), 9'($urandom_range(0, 20))};
            vpos   = {9'($urandom_range(0, 511)), 9'($urandom_range(0, 511))};
            cyc_en = 2'($urandom_range(0, 3));
         end
         tick();
      end
      HB = 1'b1;
      for (int i = 0; i < hbl; i++) begin
         pxl_cen = $urandom_range(0, 1) != 0;
         tick();
      end
   endtask

   task automatic run_frame(input bit rnd_writes);
      for (int l = 0; l < 10; l++) begin
         vdump = 9'(l);
         VB    = (l >= 7);
         run_line(24, 12, rnd_writes);
      end
      VB = 1'b0;
   endtask

   task automatic vb_pulse();
      VB = 1'b1; tick(); tick();
      VB = 1'b0; tick();
   endtask

   task automatic sample_col(output logic [2:0] col);
      vdump = 9'd0;
      HB = 1'b1; tick(); tick();
      col = star[6:4];
      HB = 1'b0; tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; pxl_cen = 1'b0; HB = 1'b0; VB = 1'b0; vdump = '0;
      hpos = '0; vpos = '0; layer_en = 2'b11; cyc_en = 2'b00;
      repeat (3) tick();
      for (int k = 0; k < LAYERS; k++) begin
         total++;
         if (star[9*k +: 9] !== 9'h00f) begin
            bad++;
            $display("FAIL reset star%0d: got %h want 00f", k, star[9*k +: 9]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_reseed();
      vdump = 9'h12;
      HB = 1'b1; tick(); tick();
      total++;
      if (star[8:0] !== 9'h05f) begin
         bad++; $display("FAIL reseed star0: got %h want 05f", star[8:0]);
      end
      total++;
      if (star[17:9] !== 9'h02f) begin
         bad++; $display("FAIL reseed star1: got %h want 02f", star[17:9]);
      end
      HB = 1'b0; tick();
   endtask

   task automatic test_preroll();
      logic [22:0] p;
      logic [8:0]  want;
      hpos = {9'd0, 9'd5}; vpos = '0; pxl_cen = 1'b0;
      vb_pulse();
      vdump = 9'h20;
      HB = 1'b1;
      repeat (12) tick();
      p = seed_of(0, 'h20);
      repeat (5) p = lfsr_next(p);
      want = {2'd0, p[6:4], 4'hf};
      total++;
      if (star[8:0] !== want) begin
         bad++; $display("FAIL preroll star0: got %h want %h", star[8:0], want);
      end
      HB = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pxl_cen = $urandom_range(0, 1) != 0;
         tick();
      end
   endtask

   task automatic test_latch();
      run_frame(1'b1);
      run_frame(1'b1);
   endtask

   task automatic test_cycle();
      logic [2:0] a;
      logic [2:0] want;
      pxl_cen = 1'b0; HB = 1'b0; hpos = '0; vpos = '0;
      cyc_en = 2'b11;
      vb_pulse();
      for (int rep = 0; rep < 2; rep++) begin
         sample_col(a);
         want = 3'((5 + ((m_fcnt >> 3) & 7)) & 7);
         total++;
         if (a !== want) begin
            bad++; $display("FAIL cycle_on col rep%0d: got %0d want %0d", rep, a, want);
         end
         repeat (8) vb_pulse();
      end
      cyc_en = 2'b00;
      vb_pulse();
      for (int rep = 0; rep < 2; rep++) begin
         sample_col(a);
         total++;
         if (a !== 3'd5) begin
            bad++; $display("FAIL cycle_off col rep%0d: got %0d want 5", rep, a);
         end
         repeat (8) vb_pulse();
      end
   endtask

   task automatic test_enable();
      layer_en = 2'b01;
      cyc_en   = 2'b10;
      hpos = {9'd3, 9'd7};
      vb_pulse();
      for (int i = 0; i < 80; i++) begin
         vdump = 9'(i / 36);
         HB = (i % 36) >= 24;
         pxl_cen = $urandom_range(0, 3) != 0;
         tick();
         total++;
         if (star[12:9] !== 4'hf) begin
            bad++; $display("FAIL enable star1 pix: got %h want f", star[12:9]);
         end
      end
      HB = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pxl_cen = 1'b1; tick();
      end
      layer_en = 2'b11;
      run_line(14, 12, 1'b0);
      run_frame(1'b0);
   endtask

   task automatic test_reset_midline();
      HB = 1'b0; VB = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pxl_cen = 1'b1; tick();
      end
      rst = 1'b1; tick();
      rst = 1'b0;
      for (int k = 0; k < LAYERS; k++) begin
         total++;
         if (star[9*k +: 9] !== 9'h00f) begin
            bad++; $display("FAIL midline_reset star%0d: got %h want 00f", k, star[9*k +: 9]);
         end
      end
      run_frame(1'b0);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 8; f++) begin
         layer_en = 2'($urandom_range(0, 3));
         run_frame(1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_reseed();
      test_preroll();
      test_latch();
      test_cycle();
      test_enable();
      test_reset_midline();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not end, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
